// File: rtl/calc_key_if.sv
// calc_key_if: keystroke and display bundle of the calculator key decoder.
//   press       - one-cycle strobe, key_val carries a new keystroke
//   key_val     - 5-bit key code (hex digit or command)
//   display     - value to show, W = 4*N_DIGITS bits
//   op_code     - latched operator (0 none, 1 ADD, 2 SUB, 3 MUL, 4 AND, 5 OR)
//   state       - 0 S_OPA, 1 S_OPB, 2 S_RES
//   digit_count - digits entered in the current operand
//   overflow    - flag from the last EXE
// The master side drives keystrokes and watches the display; the slave side
// is the decoder.
interface calc_key_if #(
    parameter int N_DIGITS = 4
) ();
    localparam int W   = 4 * N_DIGITS;
    localparam int DCW = $clog2(N_DIGITS + 1);

    logic           press;
    logic [4:0]     key_val;
    logic [W-1:0]   display;
    logic [2:0]     op_code;
    logic [1:0]     state;
    logic [DCW-1:0] digit_count;
    logic           overflow;

    modport master (
        output press, key_val,
        input  display, op_code, state, digit_count, overflow
    );

    modport slave (
        input  press, key_val,
        output display, op_code, state, digit_count, overflow
    );
endinterface

// File: rtl/calc_key_decoder.sv
// calc_key_decoder: turns keystrokes into calculator operations.
//   clk    - system clock
//   rst    - synchronous, active-high reset
//   key_if - calc_key_if slave: press/key_val in; display, op_code, state,
//            digit_count, overflow out
// Two hex operands are accumulated digit by digit, an operator is latched,
// and EXE registers the result. All updates happen on an edge where press
// is high; display is a combinational view of the registers.
module calc_key_decoder #(
    parameter int N_DIGITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    calc_key_if.slave  key_if
);
    localparam int W   = 4 * N_DIGITS;
    localparam int DCW = $clog2(N_DIGITS + 1);
    localparam logic [DCW-1:0] DC_MAX = DCW'(N_DIGITS);

    localparam logic [4:0] K_EXE = 5'h13;
    localparam logic [4:0] K_CE  = 5'h16;
    localparam logic [4:0] K_CLR = 5'h17;

    typedef enum logic [1:0] {
        S_OPA = 2'd0,
        S_OPB = 2'd1,
        S_RES = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5
    } op_e;

    state_e         state_q, state_d;
    op_e            op_code_q, op_code_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [W-1:0]   result_q, result_d;
    logic [DCW-1:0] digit_count_q, digit_count_d;
    logic           overflow_q, overflow_d;

    op_e            key_op;
    logic [W:0]     sum;
    logic [W-1:0]   diff;
    logic [2*W-1:0] prod;
    logic [W-1:0]   alu_res;
    logic           alu_ovf;
    logic           do_clear;
    logic [3:0]     digit;

    assign digit = key_val_digit(key_if.key_val);

    function automatic logic [3:0] key_val_digit(input logic [4:0] k);
        return k[3:0];
    endfunction

    // Datapath: all three arithmetic forms are computed every cycle and the
    // latched operator picks one.
    assign sum  = {1'b0, opa_q} + {1'b0, opb_q};
    assign diff = opa_q - opb_q;
    assign prod = {{W{1'b0}}, opa_q} * {{W{1'b0}}, opb_q};

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_code_q)
            OP_ADD: begin alu_res = sum[W-1:0]; alu_ovf = sum[W]; end
            OP_SUB: begin alu_res = diff;       alu_ovf = (opa_q < opb_q); end
            OP_MUL: begin alu_res = prod[W-1:0]; alu_ovf = |prod[2*W-1:W]; end
            OP_AND: alu_res = opa_q & opb_q;
            OP_OR:  alu_res = opa_q | opb_q;
            default: ;
        endcase
    end

    always_comb begin
        key_op = OP_NONE;
        case (key_if.key_val)
            5'h10: key_op = OP_ADD;
            5'h11: key_op = OP_MUL;
            5'h12: key_op = OP_AND;
            5'h14: key_op = OP_SUB;
            5'h15: key_op = OP_OR;
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        op_code_d     = op_code_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        result_d      = result_q;
        digit_count_d = digit_count_q;
        overflow_d    = overflow_q;
        do_clear      = 1'b0;

        if (key_if.press) begin
            if (!key_if.key_val[4]) begin
                // Hex digit
                case (state_q)
                    S_OPA: if (digit_count_q < DC_MAX) begin
                        opa_d         = {opa_q[W-5:0], digit};
                        digit_count_d = digit_count_q + DCW'(1);
                    end
                    S_OPB: if (digit_count_q < DC_MAX) begin
                        opb_d         = {opb_q[W-5:0], digit};
                        digit_count_d = digit_count_q + DCW'(1);
                    end
                    default: begin
                        // A digit after a result starts a fresh calculation.
                        opa_d         = {{(W-4){1'b0}}, digit};
                        digit_count_d = DCW'(1);
                        op_code_d     = OP_NONE;
                        overflow_d    = 1'b0;
                        state_d       = S_OPA;
                    end
                endcase
            end else if (key_op != OP_NONE) begin
                case (state_q)
                    S_OPA: begin
                        op_code_d     = key_op;
                        opb_d         = '0;
                        digit_count_d = '0;
                        state_d       = S_OPB;
                    end
                    S_OPB: begin
                        // The operator may be changed only before opb entry.
                        if (digit_count_q == '0)
                            op_code_d = key_op;
                    end
                    default: begin
                        // Chain: the previous result becomes the left operand.
                        opa_d         = result_q;
                        op_code_d     = key_op;
                        opb_d         = '0;
                        digit_count_d = '0;
                        state_d       = S_OPB;
                    end
                endcase
            end else if (key_if.key_val == K_EXE) begin
                if (state_q == S_OPB) begin
                    result_d   = alu_res;
                    overflow_d = alu_ovf;
                    state_d    = S_RES;
                end
            end else if (key_if.key_val == K_CE) begin
                case (state_q)
                    S_OPA: begin opa_d = '0; digit_count_d = '0; end
                    S_OPB: begin opb_d = '0; digit_count_d = '0; end
                    default: do_clear = 1'b1;
                endcase
            end else if (key_if.key_val == K_CLR) begin
                do_clear = 1'b1;
            end
            // Codes 0x18-0x1F fall through with no effect.
        end

        if (do_clear) begin
            state_d       = S_OPA;
            op_code_d     = OP_NONE;
            opa_d         = '0;
            opb_d         = '0;
            result_d      = '0;
            digit_count_d = '0;
            overflow_d    = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_OPA;
            op_code_q     <= OP_NONE;
            opa_q         <= '0;
            opb_q         <= '0;
            result_q      <= '0;
            digit_count_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_code_q     <= op_code_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            result_q      <= result_d;
            digit_count_q <= digit_count_d;
            overflow_q    <= overflow_d;
        end
    end

    always_comb begin
        key_if.display = opa_q;
        case (state_q)
            S_OPB:   key_if.display = (digit_count_q != '0) ? opb_q : opa_q;
            S_RES:   key_if.display = result_q;
            default: key_if.display = opa_q;
        endcase
    end

    assign key_if.op_code     = op_code_q;
    assign key_if.state       = state_q;
    assign key_if.digit_count = digit_count_q;
    assign key_if.overflow    = overflow_q;
endmodule

// File: tb/tb_calc_key_decoder.sv
// tb_calc_key_decoder: directed-vector bench for calc_key_decoder.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// following the rising edge that consumed the keystroke.
module tb_calc_key_decoder;
    localparam logic [4:0] K_ADD = 5'h10;
    localparam logic [4:0] K_MUL = 5'h11;
    localparam logic [4:0] K_AND = 5'h12;
    localparam logic [4:0] K_EXE = 5'h13;
    localparam logic [4:0] K_SUB = 5'h14;
    localparam logic [4:0] K_OR  = 5'h15;
    localparam logic [4:0] K_CE  = 5'h16;
    localparam logic [4:0] K_CLR = 5'h17;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    calc_key_if #(.N_DIGITS(4)) key_if ();

    calc_key_decoder #(.N_DIGITS(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .key_if (key_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic press_key(input logic [4:0] k);
        @(negedge clk);
        key_if.press   = 1'b1;
        key_if.key_val = k;
        @(negedge clk);
        key_if.press   = 1'b0;
        key_if.key_val = 5'h1F;
    endtask

    task automatic enter_hex(input logic [15:0] v);
        for (int i = 3; i >= 0; i--)
            press_key({1'b0, v[i*4 +: 4]});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst            = 1'b1;
        key_if.press   = 1'b0;
        key_if.key_val = 5'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_display", key_if.display, 16'h0000);
        check("rst_state", key_if.state, 2'd0);
        check("rst_op", key_if.op_code, 3'd0);
        check("rst_dc", key_if.digit_count, 3'd0);
        check("rst_ovf", key_if.overflow, 1'b0);

        // 1 2 ADD 3 4 EXE
        press_key(5'h01); check("add_d1", key_if.display, 16'h0001);
        press_key(5'h02); check("add_d2", key_if.display, 16'h0012);
        press_key(K_ADD); check("add_op", key_if.display, 16'h0012);
        check("add_op_state", key_if.state, 2'd1);
        press_key(5'h03); check("add_b1", key_if.display, 16'h0003);
        press_key(5'h04); check("add_b2", key_if.display, 16'h0034);
        press_key(K_EXE); check("add_res", key_if.display, 16'h0046);
        check("add_state", key_if.state, 2'd2);
        check("add_ovf", key_if.overflow, 1'b0);

        // Digit limit
        do_reset();
        for (int i = 1; i <= 4; i++) press_key(5'(i));
        check("lim_4", key_if.display, 16'h1234);
        press_key(5'h05);
        check("lim_5", key_if.display, 16'h1234);
        check("lim_dc", key_if.digit_count, 3'd4);

        // ADD carry, then a digit clears overflow
        do_reset();
        enter_hex(16'hFFFF); press_key(K_ADD); press_key(5'h01); press_key(K_EXE);
        check("carry_res", key_if.display, 16'h0000);
        check("carry_ovf", key_if.overflow, 1'b1);
        press_key(5'h02);
        check("carry_new_ovf", key_if.overflow, 1'b0);
        check("carry_new_disp", key_if.display, 16'h0002);

        // SUB borrow
        do_reset();
        press_key(5'h01); press_key(K_SUB); press_key(5'h02); press_key(K_EXE);
        check("borrow_res", key_if.display, 16'hFFFF);
        check("borrow_ovf", key_if.overflow, 1'b1);

        // MUL overflow
        do_reset();
        enter_hex(16'h0100); press_key(K_MUL); enter_hex(16'h0100); press_key(K_EXE);
        check("mul_res", key_if.display, 16'h0000);
        check("mul_ovf", key_if.overflow, 1'b1);

        // Chaining
        do_reset();
        press_key(5'h05); press_key(K_MUL); press_key(5'h03); press_key(K_EXE);
        check("chain_mul", key_if.display, 16'h000F);
        press_key(K_ADD);
        check("chain_state", key_if.state, 2'd1);
        check("chain_disp", key_if.display, 16'h000F);
        press_key(5'h01); press_key(K_EXE);
        check("chain_add", key_if.display, 16'h0010);
        check("chain_ovf", key_if.overflow, 1'b0);
        press_key(5'h07);
        check("chain_new_state", key_if.state, 2'd0);
        check("chain_new_disp", key_if.display, 16'h0007);
        check("chain_new_op", key_if.op_code, 3'd0);

        // AND, chained OR, CE in S_RES acts as CLR
        do_reset();
        press_key(5'h0F); press_key(5'h00); press_key(K_AND);
        press_key(5'h03); press_key(5'h0C); press_key(K_EXE);
        check("and_res", key_if.display, 16'h0030);
        press_key(K_OR); press_key(5'h05); press_key(K_EXE);
        check("or_res", key_if.display, 16'h0035);
        check("or_ovf", key_if.overflow, 1'b0);
        press_key(K_CE);
        check("ce_res_disp", key_if.display, 16'h0000);
        check("ce_res_state", key_if.state, 2'd0);
        check("ce_res_op", key_if.op_code, 3'd0);

        // Operator replacement, CE in S_OPB, CLR
        do_reset();
        press_key(5'h09); press_key(K_ADD); press_key(K_SUB);
        check("op_replace", key_if.op_code, 3'd2);
        press_key(5'h04);
        press_key(K_OR);
        check("op_ignored", key_if.op_code, 3'd2);
        check("op_ign_disp", key_if.display, 16'h0004);
        press_key(K_CE);
        check("ce_b_disp", key_if.display, 16'h0009);
        check("ce_b_op", key_if.op_code, 3'd2);
        press_key(K_CLR);
        check("clr_disp", key_if.display, 16'h0000);
        check("clr_state", key_if.state, 2'd0);
        check("clr_op", key_if.op_code, 3'd0);

        // Ignored code and EXE in S_OPA
        do_reset();
        press_key(5'h03);
        press_key(5'h1A);
        check("ign_disp", key_if.display, 16'h0003);
        check("ign_dc", key_if.digit_count, 3'd1);
        press_key(K_EXE);
        check("exe_opa_state", key_if.state, 2'd0);
        check("exe_opa_disp", key_if.display, 16'h0003);

        // Reset wins over a simultaneous press
        @(negedge clk);
        rst            = 1'b1;
        key_if.press   = 1'b1;
        key_if.key_val = 5'h05;
        @(negedge clk);
        rst          = 1'b0;
        key_if.press = 1'b0;
        check("rst_press_disp", key_if.display, 16'h0000);
        check("rst_press_dc", key_if.digit_count, 3'd0);

        // Back-to-back presses: 1 2 ADD 7 EXE on consecutive cycles
        @(negedge clk);
        key_if.press = 1'b1;
        key_if.key_val = 5'h01; @(negedge clk);
        key_if.key_val = 5'h02; @(negedge clk);
        key_if.key_val = K_ADD; @(negedge clk);
        key_if.key_val = 5'h07; @(negedge clk);
        key_if.key_val = K_EXE; @(negedge clk);
        key_if.press = 1'b0;
        check("b2b_res", key_if.display, 16'h0019);
        check("b2b_state", key_if.state, 2'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/calc_key_decoder.md
# calc_key_decoder

Consumes the 5-bit key codes produced by the grid cursor and turns them into calculator operations. On each one-cycle `press` strobe it interprets `key_val` as a hex digit or a command, accumulates two hex operands, latches the selected operator, and computes a registered result on EXE. Its `display` and status outputs drive the seven-segment/VGA display path.

## Interface
- `N_DIGITS`, 4, hex digits per operand; operand/result width W = 4*N_DIGITS.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `press`  in  1  one-cycle strobe: `key_val` is a new keystroke. Upstream delivers edge pulses. Every cycle with `press` high counts as one keystroke.
- `key_val`  in  5  key code: 0x00–0x0F digit; 0x10 ADD, 0x11 MUL, 0x12 AND, 0x13 EXE, 0x14 SUB, 0x15 OR, 0x16 CE, 0x17 CLR; 0x18–0x1F ignored.
- `display`  out  W  value to show (see Operation).
- `op_code`  out  3  latched operator: 0 none, 1 ADD, 2 SUB, 3 MUL, 4 AND, 5 OR.
- `state`  out  2  0 S_OPA, 1 S_OPB, 2 S_RES.
- `digit_count`  out  $clog2(N_DIGITS+1)  digits entered in the current operand.
- `overflow`  out  1  flag from the last EXE.

## Operation
- Internal registers: `opa`, `opb`, `result` (W bits each), `op_code`, `digit_count`, `overflow`, `state`.
- Reset state: S_OPA. All registers are 0. `display` = 0.
- Digit entry, in S_OPA or S_OPB:
  - If `digit_count < N_DIGITS`: operand <= {operand[W-5:0], digit}; `digit_count` + 1.
  - Otherwise the digit is ignored; no state change.
- Operator key:
  - In S_OPA: latch `op_code`; go to S_OPB; `opb` = 0; `digit_count` = 0.
  - In S_OPB with `digit_count` == 0: replace `op_code`.
  - In S_OPB with `digit_count` > 0: ignored.
  - In S_RES: `opa` <= `result`; latch `op_code`; `opb` = 0; `digit_count` = 0; go to S_OPB (chaining).
- EXE:
  - In S_OPB: `result` <= f(`opa`, `opb`); set `overflow`; go to S_RES.
  - In S_OPA or S_RES: ignored.
- Arithmetic, all modulo 2^W:
  - ADD: overflow = carry out.
  - SUB = opa − opb: overflow = borrow (opa < opb).
  - MUL: low W bits of the 2W-bit product; overflow = (high W bits ≠ 0).
  - AND, OR: overflow = 0.
- Digit in S_RES: starts a new calculation. `opa` = digit; `digit_count` = 1; `op_code` = 0; `overflow` = 0; go to S_OPA.
- CE:
  - In S_OPA: `opa` = 0; `digit_count` = 0.
  - In S_OPB: `opb` = 0; `digit_count` = 0; `op_code` is kept.
  - In S_RES: behaves as CLR.
- CLR: all registers return to their reset values; go to S_OPA.
- Codes 0x18–0x1F: no effect in any state.
- `display`, combinational from registers:
  - S_OPA: `opa`.
  - S_OPB: `opb` if `digit_count` > 0, else `opa`.
  - S_RES: `result`.

## Timing
- All state updates occur on the `clk` edge where `press` = 1. With `press` = 0, registers hold.
- Keystroke latency is 1 cycle: outputs reflect a keystroke on the edge after the cycle in which `press` is sampled high.
- EXE latency is 1 cycle. `result`, `overflow` and `state` = S_RES update on the same edge. The multiplier is combinational within the cycle.
- Back-to-back `press` on consecutive cycles is legal. Each keystroke is processed in order, with no dropped keys.
- `rst` has priority over `press`. A keystroke in the reset cycle is discarded.
- Reset mid-entry or mid-result returns everything to reset values.

## Test plan
- Reset, then keys 1, 2, ADD, 3, 4, EXE (one `press` each) -> `display` 0x0001, 0x0012, 0x0012, 0x0003, 0x0034, then 0x0046; `state` = 2; `overflow` = 0.
- Five digits 1, 2, 3, 4, 5 in S_OPA -> `display` = 0x1234 after the 4th digit, unchanged after the 5th; `digit_count` = 4.
- Entry FFFF, ADD, 1, EXE -> `display` 0x0000, `overflow` = 1. Entry 1, SUB, 2, EXE -> 0xFFFF, `overflow` = 1. Entry 0100, MUL, 0100, EXE -> 0x0000, `overflow` = 1.
- Chaining: 5, MUL, 3, EXE -> 0x000F. Then ADD, 1, EXE -> 0x0010. Then digit 7 -> `state` 0, `display` 0x0007, `op_code` 0.
- Operator handling: 9, ADD, SUB -> `op_code` = 2. Then 4, CE -> `display` 0x0009, `op_code` still 2. Then CLR -> all zero, `state` 0.
- Ignored and colliding inputs: `key_val` 0x1A and EXE in S_OPA -> no change. `rst` asserted in the same cycle as a digit press -> `display` 0, `digit_count` 0.
